// File: rtl/led_frame_arbiter_if.sv
// Pixel-source bus between the frame arbiter and its two pattern generators.
interface led_frame_arbiter_if;
   logic [1:0]  req;
   logic [31:0] pix_data0;
   logic [31:0] pix_data1;
   logic [1:0]  gnt;
   logic        pix_rdy;
   logic [5:0]  pix_idx;

   // Arbiter side.
   modport master (
      input  req, pix_data0, pix_data1,
      output gnt, pix_rdy, pix_idx
   );

   // Pixel-source side.
   modport slave (
      output req, pix_data0, pix_data1,
      input  gnt, pix_rdy, pix_idx
   );
endinterface

// File: rtl/led_frame_arbiter.sv
// Round-robin frame arbiter and serialiser for a snake-wired 8x8 LED strip:
// zero start frame, 64 MSB-first colour words, zero end frame, 2 cycles/bit.
module led_frame_arbiter #(
   parameter int unsigned START_BITS = 32,
   parameter int unsigned END_BITS   = 64
) (
   input  logic clk,
   input  logic reset,
   led_frame_arbiter_if.master bus,
   output logic led_clk,
   output logic led_data,
   output logic busy,
   output logic frame_done
);

   localparam int unsigned ZMAX = (START_BITS > END_BITS) ? START_BITS : END_BITS;
   localparam int unsigned ZW   = (ZMAX > 1) ? $clog2(ZMAX) : 1;

   typedef enum logic [1:0] {IDLE, START, PIXELS, END} state_t;

   state_t         state, state_next;
   logic           phase;        // 0 = cycle A (clock low), 1 = cycle B (clock high)
   logic [ZW-1:0]  zero_cnt;
   logic [4:0]     bit_cnt;
   logic [5:0]     pix_cnt;
   logic [31:0]    shreg;
   logic [1:0]     gnt;
   logic           pix_rdy;
   logic [5:0]     pix_idx;
   logic           last_served;

   logic           grant;
   logic           start_last;
   logic           end_last;
   logic           pix_last;
   logic [1:0]     winner;
   logic [31:0]    sel_data;

   assign bus.gnt     = gnt;
   assign bus.pix_rdy = pix_rdy;
   assign bus.pix_idx = pix_idx;

   // Physical LED position to logical {row, col}; even rows run right-to-left.
   function automatic logic [5:0] snake_idx(input logic [5:0] p);
      return {p[5:3], p[3] ? p[2:0] : ~p[2:0]};
   endfunction

   // Arbitration and terminal-count decode.
   always_comb begin
      grant      = (state == IDLE) && (bus.req != 2'b00) && !frame_done;
      start_last = (zero_cnt == ZW'(START_BITS - 1));
      end_last   = (zero_cnt == ZW'(END_BITS - 1));
      pix_last   = (bit_cnt == 5'd0) && (pix_cnt == 6'd63);
      if (bus.req == 2'b11)
         winner = last_served ? 2'b01 : 2'b10;
      else
         winner = bus.req[0] ? 2'b01 : 2'b10;
      sel_data = gnt[1] ? bus.pix_data1 : bus.pix_data0;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; frame phases advance only at the end of a B cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (grant)                state_next = START;
         START:   if (phase && start_last)  state_next = PIXELS;
         PIXELS:  if (phase && pix_last)    state_next = END;
         END:     if (phase && end_last)    state_next = IDLE;
         default:                           state_next = IDLE;
      endcase
   end

   // Direct state decode outputs.
   always_comb begin
      busy    = (state != IDLE);
      led_clk = phase;
   end

   // Bit sequencing, pixel fetch and grant bookkeeping. The fetch for the
   // next word is raised on cycle A of the current word's last bit so the
   // source has a full bit period before the word is loaded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase       <= 1'b0;
         zero_cnt    <= '0;
         bit_cnt     <= '0;
         pix_cnt     <= '0;
         shreg       <= '0;
         gnt         <= '0;
         pix_rdy     <= 1'b0;
         pix_idx     <= '0;
         led_data    <= 1'b0;
         frame_done  <= 1'b0;
         last_served <= 1'b1;
      end else begin
         pix_rdy    <= 1'b0;
         frame_done <= 1'b0;
         if (state == IDLE) begin
            phase <= 1'b0;
            if (grant) begin
               gnt      <= winner;
               zero_cnt <= '0;
               led_data <= 1'b0;
               if (START_BITS == 1) begin
                  pix_rdy <= 1'b1;
                  pix_idx <= snake_idx(6'd0);
               end
            end
         end else if (!phase) begin
            phase <= 1'b1;
         end else begin
            phase <= 1'b0;
            unique case (state)
               START: begin
                  if (start_last) begin
                     shreg    <= sel_data;
                     led_data <= sel_data[31];
                     bit_cnt  <= 5'd31;
                     pix_cnt  <= '0;
                  end else begin
                     zero_cnt <= zero_cnt + ZW'(1);
                     led_data <= 1'b0;
                     if (zero_cnt == ZW'(START_BITS - 2)) begin
                        pix_rdy <= 1'b1;
                        pix_idx <= snake_idx(6'd0);
                     end
                  end
               end
               PIXELS: begin
                  if (bit_cnt == 5'd0) begin
                     if (pix_cnt == 6'd63) begin
                        zero_cnt <= '0;
                        led_data <= 1'b0;
                     end else begin
                        pix_cnt  <= pix_cnt + 6'd1;
                        shreg    <= sel_data;
                        led_data <= sel_data[31];
                        bit_cnt  <= 5'd31;
                     end
                  end else begin
                     bit_cnt  <= bit_cnt - 5'd1;
                     led_data <= shreg[bit_cnt - 5'd1];
                     if (bit_cnt == 5'd1 && pix_cnt != 6'd63) begin
                        pix_rdy <= 1'b1;
                        pix_idx <= snake_idx(pix_cnt + 6'd1);
                     end
                  end
               end
               END: begin
                  led_data <= 1'b0;
                  if (end_last) begin
                     frame_done  <= 1'b1;
                     gnt         <= '0;
                     last_served <= gnt[1];
                  end else begin
                     zero_cnt <= zero_cnt + ZW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed bench for led_frame_arbiter: reset, single frame, snake order,
// round-robin, mid-frame request drop and asynchronous mid-frame reset.
module tb_led_frame_arbiter;

   logic clk = 1'b0;
   logic reset;
   logic led_clk, led_data, busy, frame_done;
   int   mode;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   led_frame_arbiter_if bus();

   led_frame_arbiter #(.START_BITS(32), .END_BITS(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .led_clk    (led_clk),
      .led_data   (led_data),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Pixel sources: requester 0 is constant or returns its index,
   // requester 1 returns a tagged index.
   always_comb begin
      bus.pix_data0 = (mode == 0) ? 32'hE0FF0000 : {26'd0, bus.pix_idx};
      bus.pix_data1 = {8'hC3, 18'd0, bus.pix_idx};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int logical(input int p);
      int row, col;
      row = p / 8;
      col = (row % 2 == 0) ? 7 - (p % 8) : p % 8;
      return row * 8 + col;
   endfunction

   function automatic logic [31:0] exp_word(input int who, input int md, input int p);
      logic [5:0] li;
      li = 6'(logical(p));
      if (who == 1)     return {8'hC3, 18'd0, li};
      else if (md == 0) return 32'hE0FF0000;
      else              return {26'd0, li};
   endfunction

   // Follows one frame from the first busy cycle to the frame_done cycle.
   task automatic run_frame(input logic [1:0] exp_gnt, input int md,
                            output longint start_t, output int idle_cnt);
      int who, cyc, waitc, b, w, k;
      int data_err, clk_err, gnt_err, rdy_cnt, rdy_pos_err, idx_err, done_err;
      logic [31:0] word;
      logic e, rdy_exp;
      who = exp_gnt[1] ? 1 : 0;
      cyc = 0; waitc = 0; data_err = 0; clk_err = 0; gnt_err = 0;
      rdy_cnt = 0; rdy_pos_err = 0; idx_err = 0; done_err = 0;
      idle_cnt = 0; start_t = 0;
      do begin
         @(negedge clk);
         waitc++;
         if (busy !== 1'b1) idle_cnt++;
      end while (busy !== 1'b1 && waitc < 50);
      if (busy !== 1'b1) begin
         chk("busy_timeout", 64'd0, 64'd1);
         return;
      end
      start_t = $time;
      while (busy === 1'b1 && cyc < 5000) begin
         b = cyc / 2;
         if (b >= 32 && b < 32 + 2048) begin
            w = (b - 32) / 32;
            k = (b - 32) % 32;
            word = exp_word(who, md, w);
            e = word[31 - k];
         end else begin
            e = 1'b0;
         end
         if (led_data !== e) data_err++;
         if (led_clk !== ((cyc % 2) == 1)) clk_err++;
         if (bus.gnt !== exp_gnt) gnt_err++;
         if (frame_done !== 1'b0) done_err++;
         rdy_exp = ((cyc % 2) == 0) &&
                   (b == 31 || (b >= 32 && b < 32 + 63 * 32 && ((b - 32) % 32) == 31));
         if (bus.pix_rdy !== rdy_exp) rdy_pos_err++;
         if (bus.pix_rdy === 1'b1) begin
            if (bus.pix_idx !== 6'(logical(rdy_cnt))) idx_err++;
            rdy_cnt++;
         end
         cyc++;
         @(negedge clk);
      end
      chk("busy_cycles", 64'(cyc), 64'd4288);
      chk("gnt_hold", 64'(gnt_err), 64'd0);
      chk("clk_wave", 64'(clk_err), 64'd0);
      chk("wire_data", 64'(data_err), 64'd0);
      chk("rdy_count", 64'(rdy_cnt), 64'd64);
      chk("rdy_slot", 64'(rdy_pos_err), 64'd0);
      chk("pix_idx_seq", 64'(idx_err), 64'd0);
      chk("done_early", 64'(done_err), 64'd0);
      chk("done_pulse", 64'(frame_done), 64'd1);
      chk("gnt_clear", 64'(bus.gnt), 64'd0);
   endtask

   longint t1, t2, t3;
   int     idle;

   initial begin
      reset   = 1'b0;
      bus.req = 2'b11;
      mode    = 0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {bus.gnt, bus.pix_rdy, bus.pix_idx, led_clk, led_data, busy, frame_done}, 64'd0);
      reset = 1'b1;

      // Tie after reset: requester 0, constant colour word.
      run_frame(2'b01, 0, t1, idle);
      chk("grant_latency", 64'(idle), 64'd0);

      // Tie persists: requester 1 next, then requester 0 with snake data.
      run_frame(2'b10, 0, t2, idle);
      chk("rr_gap", 64'(idle >= 1), 64'd1);
      chk("frame_period", 64'((t2 - t1) / 10), 64'd4290);
      mode = 1;
      run_frame(2'b01, 1, t3, idle);
      chk("rr_gap2", 64'(idle >= 1), 64'd1);
      bus.req = 2'b00;

      repeat (20) @(negedge clk);
      chk("stay_idle", {busy, bus.gnt}, 64'd0);

      // Request dropped around pixel 20; frame must still complete.
      bus.req = 2'b01;
      fork
         run_frame(2'b01, 1, t1, idle);
         begin
            repeat ((32 + 20 * 32) * 2 + 5) @(negedge clk);
            bus.req = 2'b00;
         end
      join
      repeat (20) @(negedge clk);
      chk("idle_after_drop", {busy, bus.gnt, frame_done}, 64'd0);

      // Asynchronous reset in the middle of pixel 30, between clock edges.
      mode    = 0;
      bus.req = 2'b01;
      for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
      chk("busy_before_rst", 64'(busy), 64'd1);
      repeat ((32 + 30 * 32) * 2 + 3) @(negedge clk);
      #2 reset = 1'b0;
      #1 chk("async_rst", {bus.gnt, bus.pix_rdy, bus.pix_idx, led_clk, led_data, busy, frame_done}, 64'd0);
      bus.req = 2'b10;
      mode    = 1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      run_frame(2'b10, 1, t1, idle);
      bus.req = 2'b00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
